// File: rtl/rs_ctrl_pkg.sv
// Shared types, default sizes and helpers for the RS decoder frame controller.
package rs_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        PAD  = 2'd2
    } in_state_t;

    // Sizes for the default configuration (N=255, CHECK=8); modules that take
    // N/CHECK as parameters derive their own widths with the functions below.
    localparam int DEF_N      = 255;
    localparam int DEF_CHECK  = 8;
    localparam int IDXW       = $clog2(DEF_N);
    localparam int W          = $clog2(DEF_CHECK / 2 + 1);
    localparam int PADF_DEPTH = 4;

    // Symbol index width for an n-symbol codeword (n >= 2).
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Width of the corrected-symbol count reported by the decoder.
    function automatic int nerr_w(input int check);
        return (check >= 2) ? $clog2(check / 2 + 1) : 1;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rs_pad_tag_fifo.sv
// Small FIFO of 1-bit "block was zero-padded" tags, matching input codewords
// to the decoder output blocks that come out later.
module rs_pad_tag_fifo
    import rs_ctrl_pkg::*;
#(
    parameter int DEPTH = PADF_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // Storage, pointers and occupancy; push+pop together leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
            end
            if (do_pop)
                rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rs_dec_frame_ctrl.sv
// Frames the incoming symbol stream into N-symbol codewords for the RS lane
// decoder (zero-padding stalled codewords), strips parity from the decoder
// output and reports per-block status and saturating statistics.
module rs_dec_frame_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int M       = 8,
    parameter int N       = 255,
    parameter int CHECK   = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNTW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [M-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       dec_sink_ena,
    output logic                       dec_sink_val,
    output logic                       dec_sink_sop,
    output logic                       dec_sink_eop,
    output logic [M-1:0]               dec_rsin,
    output logic                       dec_source_ena,
    input  logic                       dec_source_val,
    input  logic                       dec_source_sop,
    input  logic                       dec_source_eop,
    input  logic [M-1:0]               dec_rsout,
    input  logic [nerr_w(CHECK)-1:0]   dec_num_err_sym,
    input  logic                       dec_decfail,
    output logic                       dec_bypass,
    input  logic                       cfg_bypass,
    output logic [M-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       blk_done,
    output logic                       blk_fail,
    output logic [nerr_w(CHECK)-1:0]   blk_nerr,
    output logic                       blk_padded,
    output logic [CNTW-1:0]            blk_cnt,
    output logic [CNTW-1:0]            fail_cnt
);
    localparam int IDX_W   = idx_w(N);
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam int PAYLOAD = N - CHECK;

    in_state_t        state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [TO_W-1:0]  idle_cnt, idle_nx;
    logic             fire;
    logic             pf_push, pf_tag, pf_pop, pf_head, pf_full, pf_empty;

    logic [IDX_W-1:0] oidx, cur_oidx;
    logic             in_parity, src_acc;

    // Input state, symbol index and mid-codeword idle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            idle_cnt <= idle_nx;
        end
    end

    // Zero-latency sink drive plus next-state; a full tag FIFO holds off sop.
    always_comb begin
        in_ready     = 1'b0;
        dec_sink_val = 1'b0;
        dec_sink_sop = 1'b0;
        dec_sink_eop = 1'b0;
        dec_rsin     = '0;
        state_nx     = state;
        idx_nx       = idx;
        idle_nx      = idle_cnt;
        pf_push      = 1'b0;
        pf_tag       = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    in_ready     = dec_sink_ena && !pf_full;
                    dec_sink_val = in_valid && !pf_full;
                    dec_rsin     = in_data;
                end
                FEED: begin
                    in_ready     = dec_sink_ena;
                    dec_sink_val = in_valid;
                    dec_rsin     = in_data;
                end
                PAD: begin
                    dec_sink_val = 1'b1;
                    dec_rsin     = '0;
                end
                default: ;
            endcase
            dec_sink_sop = dec_sink_val && (state == IDLE);
            dec_sink_eop = dec_sink_val && (idx == IDX_W'(N - 1));
        end
        fire = dec_sink_val && dec_sink_ena;

        unique case (state)
            IDLE: begin
                if (fire) begin
                    state_nx = FEED;
                    idx_nx   = IDX_W'(1);
                    idle_nx  = '0;
                end
            end
            FEED: begin
                if (fire) begin
                    idle_nx = '0;
                    if (idx == IDX_W'(N - 1)) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        pf_push  = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nx = PAD;
                    idle_nx  = '0;
                end else begin
                    idle_nx = idle_cnt + TO_W'(1);
                end
            end
            PAD: begin
                if (fire) begin
                    if (idx == IDX_W'(N - 1)) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        pf_push  = 1'b1;
                        pf_tag   = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    rs_pad_tag_fifo #(.DEPTH(PADF_DEPTH)) u_pad_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pf_push),
        .din   (pf_tag),
        .pop   (pf_pop),
        .dout  (pf_head),
        .full  (pf_full),
        .empty (pf_empty)
    );

    // Output side: sop restarts the index on its own beat; parity beats are
    // always accepted so a stalled consumer never blocks the decoder tail.
    assign cur_oidx       = dec_source_sop ? '0 : oidx;
    assign in_parity      = (cur_oidx >= IDX_W'(PAYLOAD));
    assign dec_source_ena = !reset && (out_ready || in_parity);
    assign src_acc        = dec_source_val && dec_source_ena;
    assign out_valid      = !reset && dec_source_val && !in_parity;
    assign out_data       = reset ? '0 : dec_rsout;
    assign pf_pop         = src_acc && dec_source_eop;

    // Output symbol index; returns to 0 after eop so idle ena tracks out_ready.
    always_ff @(posedge clk) begin
        if (reset)
            oidx <= '0;
        else if (src_acc)
            oidx <= dec_source_eop ? '0 : cur_oidx + IDX_W'(1);
    end

    // Block status pulse one cycle after the accepted eop, plus statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_done   <= 1'b0;
            blk_fail   <= 1'b0;
            blk_nerr   <= '0;
            blk_padded <= 1'b0;
            blk_cnt    <= '0;
            fail_cnt   <= '0;
        end else begin
            blk_done <= pf_pop;
            if (pf_pop) begin
                blk_fail   <= dec_decfail;
                blk_nerr   <= dec_num_err_sym;
                blk_padded <= !pf_empty && pf_head;
                blk_cnt    <= CNTW'(sat_inc(32'(blk_cnt), CNTW));
                if (dec_decfail)
                    fail_cnt <= CNTW'(sat_inc(32'(fail_cnt), CNTW));
            end
        end
    end

    // Bypass is only allowed to change between codewords.
    always_ff @(posedge clk) begin
        if (reset)
            dec_bypass <= 1'b0;
        else if (state == IDLE)
            dec_bypass <= cfg_bypass;
    end

endmodule

// File: tb/tb_rs_dec_frame_ctrl.sv
// Directed, table-driven bench for rs_dec_frame_ctrl. The bench plays the
// role of the RS decoder on the output side.
module tb_rs_dec_frame_ctrl;
    localparam int M = 8, N = 12, CHECK = 4, TIMEOUT = 6, CNTW = 4, W = 2;
    localparam int PAY = N - CHECK;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0, reset;
    logic [M-1:0] in_data, dec_rsin, dec_rsout, out_data;
    logic in_valid, in_ready, dec_sink_ena, dec_sink_val, dec_sink_sop, dec_sink_eop;
    logic dec_source_ena, dec_source_val, dec_source_sop, dec_source_eop;
    logic [W-1:0] dec_num_err_sym, blk_nerr;
    logic dec_decfail, dec_bypass, cfg_bypass, out_valid, out_ready;
    logic blk_done, blk_fail, blk_padded;
    logic [CNTW-1:0] blk_cnt, fail_cnt;

    int checks = 0, failures = 0;
    int exp_blk = 0, exp_fail = 0;

    always #5 clk = ~clk;

    rs_dec_frame_ctrl #(.M(M), .N(N), .CHECK(CHECK), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dec_sink_ena(dec_sink_ena), .dec_sink_val(dec_sink_val),
        .dec_sink_sop(dec_sink_sop), .dec_sink_eop(dec_sink_eop), .dec_rsin(dec_rsin),
        .dec_source_ena(dec_source_ena), .dec_source_val(dec_source_val),
        .dec_source_sop(dec_source_sop), .dec_source_eop(dec_source_eop),
        .dec_rsout(dec_rsout), .dec_num_err_sym(dec_num_err_sym), .dec_decfail(dec_decfail),
        .dec_bypass(dec_bypass), .cfg_bypass(cfg_bypass),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .blk_done(blk_done), .blk_fail(blk_fail), .blk_nerr(blk_nerr),
        .blk_padded(blk_padded), .blk_cnt(blk_cnt), .fail_cnt(fail_cnt)
    );

    // One row = one cycle of decoder output stimulus and expected response.
    typedef struct {
        int val, sop, eop, d, rdy, fail, nerr;
        int e_ena, e_ov, e_done;
    } orow_t;
    orow_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic feed_frame(input int n, input bit c);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); dec_sink_ena = 1'b1;
            #1;
            if (c) begin
                chk("feed_rdy", 32'(in_ready), 32'd1);
                chk("feed_sop", 32'(dec_sink_sop), 32'(i == 0));
                chk("feed_eop", 32'(dec_sink_eop), 32'(i == N - 1));
                chk("feed_data", 32'(dec_rsin), 32'(i + 1));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic out_block(input bit f, input logic [W-1:0] ne, input bit pad);
        for (int i = 0; i < N; i++) begin
            dec_source_val = 1'b1; dec_source_sop = (i == 0); dec_source_eop = (i == N - 1);
            dec_rsout = 8'(64 + i); dec_decfail = f && (i == N - 1);
            dec_num_err_sym = (i == N - 1) ? ne : '0; out_ready = 1'b1;
            #1;
            chk("ob_ovalid", 32'(out_valid), 32'(i < PAY));
            tick();
        end
        dec_source_val = 1'b0; dec_source_sop = 1'b0; dec_source_eop = 1'b0;
        dec_decfail = 1'b0; dec_num_err_sym = '0; out_ready = 1'b0;
        exp_blk = sat(exp_blk);
        if (f) exp_fail = sat(exp_fail);
        chk("ob_done", 32'(blk_done), 32'd1);
        chk("ob_fail", 32'(blk_fail), 32'(f));
        chk("ob_nerr", 32'(blk_nerr), 32'(ne));
        chk("ob_padded", 32'(blk_padded), 32'(pad));
        chk("ob_blk_cnt", 32'(blk_cnt), 32'(exp_blk));
        chk("ob_fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        tick();
        chk("ob_done_pulse", 32'(blk_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, pads, beats, cyc;
        bit seen, ena;
        // val sop eop data rdy fail nerr | ena ov done
        tbl[0]  = '{1, 1, 0, 'hA0, 1, 0, 0, 1, 1, 0};
        tbl[1]  = '{1, 0, 0, 'hA1, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 0, 0, 'hA1, 1, 0, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 'h00, 1, 0, 0, 1, 0, 0};
        for (int k = 0; k < 6; k++) tbl[4 + k] = '{1, 0, 0, 'hA2 + k, 1, 0, 0, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 'hB0, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 0, 'hB1, 0, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 'hB2, 0, 0, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 1, 'hB3, 0, 0, 2, 1, 0, 1};
        tbl[14] = '{0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0};

        // Reset: outputs forced low even with active inputs.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A; dec_sink_ena = 1'b1;
        dec_source_val = 1'b1; dec_source_sop = 1'b0; dec_source_eop = 1'b0;
        dec_rsout = 8'h33; dec_num_err_sym = '0; dec_decfail = 1'b0;
        cfg_bypass = 1'b1; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sink_val", 32'(dec_sink_val), 32'd0);
        chk("rst_src_ena", 32'(dec_source_ena), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); tick();
        chk("rst_done", 32'(blk_done), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_bypass", 32'(dec_bypass), 32'd0);
        in_valid = 1'b0; dec_source_val = 1'b0; cfg_bypass = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        tick();

        // Clean codeword at full rate: sop on beat 0, eop on beat N-1.
        feed_frame(N, 1'b1);

        // Sink backpressure 1010...: no loss/duplication, in_ready follows ena.
        beats = 0; cyc = 0;
        while (beats < N && cyc < 4 * N) begin
            ena = (cyc % 2 == 0);
            dec_sink_ena = ena; in_valid = 1'b1; in_data = 8'(128 + beats);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'(ena));
            if (ena) begin
                chk("bp_data", 32'(dec_rsin), 32'(128 + beats));
                chk("bp_sop", 32'(dec_sink_sop), 32'(beats == 0));
                chk("bp_eop", 32'(dec_sink_eop), 32'(beats == N - 1));
            end
            tick();
            if (ena) beats++;
            cyc++;
        end
        in_valid = 1'b0; dec_sink_ena = 1'b1;
        chk("bp_beats", 32'(beats), 32'(N));

        // Output side table: payload forwarding, consumer stalls, parity drop.
        for (int r = 0; r < 15; r++) begin
            dec_source_val = tbl[r].val[0]; dec_source_sop = tbl[r].sop[0];
            dec_source_eop = tbl[r].eop[0]; dec_rsout = 8'(tbl[r].d);
            out_ready = tbl[r].rdy[0]; dec_decfail = tbl[r].fail[0];
            dec_num_err_sym = W'(tbl[r].nerr);
            #1;
            chk("tbl_src_ena", 32'(dec_source_ena), 32'(tbl[r].e_ena));
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[r].e_ov));
            if (tbl[r].e_ov != 0) chk("tbl_out_data", 32'(out_data), 32'(tbl[r].d));
            tick();
            chk("tbl_done", 32'(blk_done), 32'(tbl[r].e_done));
            if (tbl[r].e_done != 0) begin
                chk("tbl_fail", 32'(blk_fail), 32'(tbl[r].fail));
                chk("tbl_nerr", 32'(blk_nerr), 32'(tbl[r].nerr));
                chk("tbl_padded", 32'(blk_padded), 32'd0);
            end
        end
        exp_blk = 1;
        chk("tbl_blk_cnt", 32'(blk_cnt), 32'(exp_blk));

        // Timeout: 5 symbols then silence; TIMEOUT idle cycles, then zero pad.
        feed_frame(5, 1'b0);
        #1;
        cnt = 0;
        while (!dec_sink_val && cnt < 4 * TIMEOUT) begin
            tick();
            cnt++;
        end
        chk("to_idle_cycles", 32'(cnt), 32'(TIMEOUT));
        pads = 0; seen = 1'b0;
        while (!seen && pads < 2 * N) begin
            in_valid = 1'b1; in_data = 8'hFF;
            #1;
            chk("pad_val", 32'(dec_sink_val), 32'd1);
            chk("pad_in_ready", 32'(in_ready), 32'd0);
            chk("pad_data", 32'(dec_rsin), 32'd0);
            seen = dec_sink_eop;
            tick();
            pads++;
        end
        in_valid = 1'b0;
        chk("pad_beats", 32'(pads), 32'(N - 5));
        chk("pad_eop", 32'(seen), 32'd1);
        out_block(1'b0, 2'd0, 1'b0);
        out_block(1'b0, 2'd0, 1'b1);

        // Corrected block then an uncorrectable one.
        out_block(1'b0, 2'd2, 1'b0);
        out_block(1'b1, 2'd0, 1'b0);

        // Tag FIFO full: four codewords in flight hold off the next sop.
        repeat (4) feed_frame(N, 1'b0);
        in_valid = 1'b1; dec_sink_ena = 1'b1;
        repeat (3) begin
            #1;
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_sink_val", 32'(dec_sink_val), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_block(1'b1, 2'd1, 1'b0);
        feed_frame(7, 1'b1);

        // Reset mid-codeword: partial frame dropped, counters cleared.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_sink_val", 32'(dec_sink_val), 32'd0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        exp_blk = 0; exp_fail = 0;
        chk("mrst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("mrst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("mrst_done", 32'(blk_done), 32'd0);
        feed_frame(N, 1'b1);

        // Saturation: 20 failing blocks on 4-bit counters.
        repeat (20) out_block(1'b1, 2'd0, 1'b0);
        chk("sat_blk_cnt", 32'(blk_cnt), 32'(CMAX));
        chk("sat_fail_cnt", 32'(fail_cnt), 32'(CMAX));

        // Bypass only follows cfg_bypass between codewords.
        cfg_bypass = 1'b1;
        tick();
        chk("byp_idle_set", 32'(dec_bypass), 32'd1);
        feed_frame(1, 1'b0);
        cfg_bypass = 1'b0;
        tick();
        chk("byp_hold_mid", 32'(dec_bypass), 32'd1);
        feed_frame(N - 1, 1'b0);
        tick();
        chk("byp_idle_clr", 32'(dec_bypass), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_dec_frame_ctrl.md
Name: rs_dec_frame_ctrl

Overview:
- Sequences the Reed-Solomon lane decoder (RS_DE_LANE_QUATUS) between the UART receive byte stream and the downstream payload consumer.
- Input side: frames incoming symbols into N-symbol codewords with sop/eop and honours the decoder's sink_ena backpressure. Pads a stalled partial codeword with zeros.
- Output side: strips the CHECK parity symbols from the decoder output and forwards payload. Reports per-block status and keeps block/failure counters.

Parameters:
- M, 8, symbol width in bits (matches decoder m).
- N, 255, codeword length in symbols (2..2^M-1).
- CHECK, 8, parity symbols per codeword (matches decoder check); N-CHECK >= 1.
- TIMEOUT, 4096, idle cycles mid-codeword before zero padding starts (>= 1).
- CNTW, 16, width of the block and failure statistic counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  M  received symbol from UART deframer
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data this cycle
- dec_sink_ena  in  1  decoder ready to accept a symbol
- dec_sink_val  out  1  symbol valid to decoder
- dec_sink_sop  out  1  first symbol of codeword
- dec_sink_eop  out  1  last symbol of codeword
- dec_rsin  out  M  symbol to decoder
- dec_source_ena  out  1  controller ready for decoder output
- dec_source_val  in  1  decoder output valid
- dec_source_sop  in  1  decoder output first symbol
- dec_source_eop  in  1  decoder output last symbol
- dec_rsout  in  M  corrected symbol
- dec_num_err_sym  in  W  corrected symbol count; W = clog2(CHECK/2+1), qualified by dec_source_eop
- dec_decfail  in  1  uncorrectable block flag, qualified by dec_source_eop
- dec_bypass  out  1  decoder bypass, registered copy of cfg_bypass
- cfg_bypass  in  1  bypass request
- out_data  out  M  payload symbol
- out_valid  out  1  payload valid
- out_ready  in  1  downstream ready
- blk_done  out  1  one-cycle pulse at end of each decoded block
- blk_fail  out  1  dec_decfail of that block, valid with blk_done
- blk_nerr  out  W  dec_num_err_sym of that block, valid with blk_done
- blk_padded  out  1  block was zero-padded, valid with blk_done
- blk_cnt  out  CNTW  blocks decoded, saturating
- fail_cnt  out  CNTW  failed blocks, saturating

Behaviour:
- Reset: every output is 0, except dec_source_ena, which is 0 during reset and then follows its rule. All counters and the pad FIFO clear; the FSM goes to IDLE. A reset mid-codeword discards the partial frame with no eop; the decoder shares the same reset.
- Input transfer: a beat fires when dec_sink_val && dec_sink_ena. in_ready = dec_sink_ena && state is IDLE or FEED. dec_rsin, dec_sink_val, dec_sink_sop and dec_sink_eop are combinational from in_data/in_valid and the symbol index, so the input path has zero latency.
- Input FSM states:
  - IDLE: index = 0. On a fired beat assert sop and go to FEED with index = 1.
  - FEED: each fired beat increments index. eop is asserted when index = N-1, then return to IDLE.
  - FEED timeout: the idle counter counts cycles with no fired beat and clears on any beat. At TIMEOUT go to PAD.
  - PAD: drive 0 symbols with val = 1 while dec_sink_ena, until the eop beat at index N-1. in_ready = 0. Set the pad tag; return to IDLE.
- Pad tag FIFO: 4-entry FIFO of padded flags, pushed on each input eop and popped on each output eop. When the FIFO is full, in_ready and PAD val are held 0 at sop until an entry pops.
- Output side:
  - dec_source_ena = out_ready || (output index >= N-CHECK).
  - The output index resets to 0 on dec_source_sop and increments per accepted beat (dec_source_val && dec_source_ena).
  - Beats with index < N-CHECK are forwarded as out_data = dec_rsout, out_valid = dec_source_val. Parity beats are dropped.
- Block status: on the accepted eop beat, the next cycle pulses blk_done with blk_fail, blk_nerr and blk_padded registered (latency 1).
  - blk_cnt increments, saturating at all-ones.
  - fail_cnt increments when decfail, saturating.
- Simultaneous FIFO push and pop: the count is unchanged.
- cfg_bypass changes take effect only in IDLE; the registered dec_bypass is updated there.
- N = CHECK+1 gives one payload symbol per block, which is legal.

Decomposition:
- Package rs_ctrl_pkg:
  - in_state_t enum (IDLE, FEED, PAD)
  - localparams IDXW = clog2(N), W, PADF_DEPTH = 4
  - helper function sat_inc
- One sub-module: rs_pad_tag_fifo, a 1-bit, 4-deep synchronous FIFO with push, pop, full and empty.

Test Plan:
- Clean block: N=255, CHECK=8, 255 valid encoded symbols with no errors, dec_sink_ena = 1 → sop on beat 0, eop on beat 254. out emits exactly 247 symbols equal to the payload. blk_done pulse with fail=0, nerr=0, padded=0; blk_cnt = 1.
- Backpressure: dec_sink_ena toggles 1010..., out_ready is random 50% → no lost or duplicated symbols, and in_ready = 0 whenever dec_sink_ena = 0. Parity beats complete even with out_ready = 0.
- Timeout pad: feed 100 symbols, then stop, with TIMEOUT=16 → after 16 idle cycles the controller emits 155 zero symbols, eop at index 254. blk_padded = 1 and in_ready = 0 throughout PAD.
- Errors: inject 4 symbol errors, then 5 in the next block → block 1 has fail=0, nerr=4 with the payload corrected. Block 2 has fail=1; fail_cnt = 1, blk_cnt = 2.
- Reset mid-frame: reset asserted for 1 cycle at input index 60 → all outputs go to 0 and the next sop starts a new frame with index 0. Counters read 0.
- Saturation: CNTW=4, 20 failing blocks → blk_cnt = fail_cnt = 15 with no wrap.
